// File: rtl/sobel_stream_bist.sv
// sobel_stream_bist: APB-programmed test-frame source and MISR result sink for the Sobel pipeline.
// Define SOBEL_BIST_HBLANK_EN to insert HBLANK idle cycles between generated lines.
module sobel_stream_bist #(
  parameter int PIX_W    = 8,
  parameter int CHANNELS = 1,
  parameter int DIM_W    = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [31:0]               PADDR,
  input  logic [31:0]               PWDATA,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [PIX_W*CHANNELS-1:0] tx_pixel,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  input  logic [PIX_W*CHANNELS-1:0] rx_pixel,
  input  logic                      rx_valid,
  output logic                      bist_done
);
  localparam int PW = PIX_W * CHANNELS;
  localparam int CW = 2 * DIM_W;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [DIM_W-1:0] width, height, x, y, x_nx, y_nx;
  logic [15:0] seed, lfsr, lfsr_step, seed_eff, dcnt;
  logic [31:0] exp_sig, sig, rd;
  logic [1:0] mode, mode_cur;
  logic [CW-1:0] tx_cnt, rx_cnt, tx_cnt_inc, rx_cnt_inc, total;
  logic done, sig_match, cfg_err, timeout, busy, acc, wr_ok, cfg_wr, ctrl_idle;
  logic start, abort, mapped, ro, xfer, x_last, go, run_rx, rx_all, drain_to;
  logic [7:0] a;
  logic unused_paddr;
`ifdef SOBEL_BIST_HBLANK_EN
  logic [7:0] hblank, gap;
`endif
  function automatic logic [PW-1:0] pat(input logic [DIM_W-1:0] px, input logic [DIM_W-1:0] py,
                                        input logic [15:0] l, input logic [15:0] sd, input logic [1:0] m);
    logic [31:0] s;
    pat = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      s = 32'(px) + 32'(py) + 32'(c);
      pat[c*PIX_W +: PIX_W] = m == 2'd0 ? PIX_W'(s)
                            : m == 2'd1 ? {PIX_W{px[3] ^ py[3]}} ^ PIX_W'(c)
                            : m == 2'd2 ? PIX_W'(l) ^ PIX_W'(c) : PIX_W'(sd);
    end
  endfunction
  // Wide pixels fold onto the signature as the XOR of their 32-bit slices.
  function automatic logic [31:0] fold(input logic [PW-1:0] p);
    fold = '0;
    for (int i = 0; i < PW; i++) fold[i % 32] = fold[i % 32] ^ p[i];
  endfunction
  assign a            = PADDR[7:0];
  assign unused_paddr = ^PADDR[31:8];
  assign acc       = PSEL & PENABLE;
  assign mapped    = a inside {8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24};
  assign ro        = a inside {8'h10, 8'h14, 8'h18, 8'h1C};
  assign PSLVERR   = acc & (~mapped | (PWRITE & ro));
  assign PREADY    = 1'b1;
  assign wr_ok     = acc & PWRITE & mapped & ~ro;
  assign busy      = state != IDLE;
  assign cfg_wr    = wr_ok & ~busy;
  assign ctrl_idle = cfg_wr && a == 8'h00;
  assign start     = wr_ok && a == 8'h00 && PWDATA[0];
  assign abort     = wr_ok && a == 8'h00 && PWDATA[1];
  assign mode_cur  = ctrl_idle ? PWDATA[3:2] : mode;
  assign total      = CW'(width) * CW'(height);
  assign tx_cnt_inc = tx_cnt == '1 ? tx_cnt : tx_cnt + 1'b1;
  assign rx_cnt_inc = rx_cnt == '1 ? rx_cnt : rx_cnt + 1'b1;
  assign x_last     = x == width - 1'b1;
  assign x_nx       = x_last ? '0 : x + 1'b1;
  assign y_nx       = x_last ? y + 1'b1 : y;
  assign lfsr_step  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign seed_eff   = seed == 16'd0 ? 16'd1 : seed;
`ifdef SOBEL_BIST_HBLANK_EN
  assign tx_valid   = state == RUN && gap == 8'd0;
`else
  assign tx_valid   = state == RUN;
`endif
  assign xfer       = tx_valid & tx_ready;
  assign bist_done  = state == DONE;
  assign run_rx     = (state == RUN || state == DRAIN) && rx_valid;
  assign rx_all     = rx_cnt == total;
  assign drain_to   = dcnt == 16'hFFFE;
  assign go         = state == IDLE && state_nx == RUN;
  always_comb begin
    state_nx = abort ? IDLE
             : state == IDLE  ? ((start && width != '0 && height != '0) ? RUN : IDLE)
             : state == RUN   ? ((xfer && tx_cnt_inc == total) ? DRAIN : RUN)
             : state == DRAIN ? ((rx_all || drain_to) ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    rd = '0;
    case (a)
      8'h00: rd = {28'd0, mode, 2'b00};
      8'h04: rd = 32'(width);
      8'h08: rd = 32'(height);
      8'h0C: rd = {16'd0, seed};
      8'h10: rd = {27'd0, timeout, cfg_err, sig_match, done, busy};
      8'h14: rd = 32'(tx_cnt);
      8'h18: rd = 32'(rx_cnt);
      8'h1C: rd = sig;
      8'h20: rd = exp_sig;
`ifdef SOBEL_BIST_HBLANK_EN
      8'h24: rd = {24'd0, hblank};
`endif
      default: rd = '0;
    endcase
    PRDATA = (PSEL && !PWRITE) ? rd : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      width <= '0; height <= '0; seed <= '0; exp_sig <= '0; mode <= '0;
      done <= 1'b0; sig_match <= 1'b0; cfg_err <= 1'b0; timeout <= 1'b0;
      tx_cnt <= '0; rx_cnt <= '0; x <= '0; y <= '0; lfsr <= '0; dcnt <= '0;
      sig <= '1; tx_pixel <= '0;
`ifdef SOBEL_BIST_HBLANK_EN
      hblank <= '0; gap <= '0;
`endif
    end else begin
      if (cfg_wr && a == 8'h04) width <= PWDATA[DIM_W-1:0];
      if (cfg_wr && a == 8'h08) height <= PWDATA[DIM_W-1:0];
      if (cfg_wr && a == 8'h0C) seed <= PWDATA[15:0];
`ifdef SOBEL_BIST_HBLANK_EN
      if (cfg_wr && a == 8'h24) hblank <= PWDATA[7:0];
`endif
      if (wr_ok && a == 8'h20) exp_sig <= PWDATA;
      if (ctrl_idle) mode <= PWDATA[3:2];
      if (ctrl_idle && PWDATA[0] && !PWDATA[1]) cfg_err <= width == '0 || height == '0;
      if (go) begin
        x <= '0; y <= '0; tx_cnt <= '0; rx_cnt <= '0; dcnt <= '0;
        done <= 1'b0; timeout <= 1'b0; sig <= '1; lfsr <= seed_eff;
        tx_pixel <= pat('0, '0, seed_eff, seed, mode_cur);
`ifdef SOBEL_BIST_HBLANK_EN
        gap <= '0;
`endif
      end else if (!abort) begin
        // The next beat's pixel is prepared on the transfer so tx_pixel stays a flop.
        if (xfer) begin
          x <= x_nx; y <= y_nx; tx_cnt <= tx_cnt_inc; lfsr <= lfsr_step;
          tx_pixel <= pat(x_nx, y_nx, lfsr_step, seed, mode);
        end
        if (run_rx) begin
          rx_cnt <= rx_cnt_inc;
          sig <= {sig[30:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]} ^ fold(rx_pixel);
        end
        dcnt <= state == DRAIN ? dcnt + 16'd1 : '0;
        if (state == DRAIN && drain_to && !rx_all) timeout <= 1'b1;
        if (state == DONE) begin
          done <= 1'b1;
          sig_match <= sig == exp_sig;
        end
`ifdef SOBEL_BIST_HBLANK_EN
        gap <= (xfer && x_last && tx_cnt_inc != total) ? hblank : gap == 8'd0 ? 8'd0 : gap - 8'd1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_sobel_stream_bist.sv
// tb_sobel_stream_bist: directed frames through the BIST with a pixel scoreboard and
// a 3-cycle rx echo loop feeding the signature.
module tb_sobel_stream_bist;
  logic clk = 1'b0, reset = 1'b1;
  logic PSEL = 0, PENABLE = 0, PWRITE = 0, PREADY, PSLVERR;
  logic [31:0] PADDR = 0, PWDATA = 0, PRDATA;
  logic [7:0] tx_pixel, rx_pixel = 0;
  logic tx_valid, tx_ready = 1, rx_valid = 0, bist_done;
  int tests = 0, fails = 0, cyc = 0, done_cyc = 0, done_at = 0, last_xfer = 0, tx_mode = 0;
  bit echo_en = 1, stalled = 0;
  logic [7:0] held = 0;
  logic [7:0] exp_q[$], vec[$];
  int xfer_t[$];
  logic [2:0] pv = 0;
  logic [7:0] pd[3] = '{0, 0, 0};

  sobel_stream_bist dut (
    .clk(clk), .reset(reset), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .tx_pixel(tx_pixel), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_pixel(rx_pixel), .rx_valid(rx_valid), .bist_done(bist_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted beat pops one expected pixel.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (bist_done) begin done_cyc++; done_at = cyc; end
    if (tx_valid && stalled) chk("stall_hold", 32'(tx_pixel), 32'(held));
    stalled = tx_valid && !tx_ready;
    held = tx_pixel;
    if (tx_valid && tx_ready) begin
      last_xfer = cyc;
      xfer_t.push_back(cyc);
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL extra_beat: got 0x%0h, expected no beat", tx_pixel);
      end else chk("tx_pixel", 32'(tx_pixel), 32'(exp_q.pop_front()));
    end
  end

  // rx echo: accepted tx beats come back 3 cycles later.
  initial forever begin
    @(negedge clk);
    rx_valid = echo_en && pv[2];
    rx_pixel = pd[2];
    pv = {pv[1:0], tx_valid && tx_ready};
    pd[2] = pd[1]; pd[1] = pd[0]; pd[0] = tx_pixel;
  end

  initial forever begin
    @(posedge clk); #1;
    if (tx_mode == 0) tx_ready = 1'b1;
    else if (tx_mode == 1) tx_ready = ~tx_ready;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apb_write(input logic [31:0] ad, input logic [31:0] d, output logic err);
    @(posedge clk); #1 PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = ad; PWDATA = d;
    @(posedge clk); #1 PENABLE = 1;
    @(negedge clk); err = PSLVERR;
    @(posedge clk); #1 PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic apb_read(input logic [31:0] ad, output logic [31:0] d, output logic err);
    @(posedge clk); #1 PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = ad;
    @(posedge clk); #1 PENABLE = 1;
    @(negedge clk); d = PRDATA; err = PSLVERR;
    @(posedge clk); #1 PSEL = 0; PENABLE = 0;
  endtask

  task automatic wr(input logic [31:0] ad, input logic [31:0] d);
    logic e;
    apb_write(ad, d, e);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] ad, input logic [31:0] exp);
    logic [31:0] d;
    logic e;
    apb_read(ad, d, e);
    chk(name, d, exp);
  endtask

  function automatic logic [31:0] misr_model();
    logic [31:0] s = '1;
    foreach (vec[i]) s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ {24'd0, vec[i]};
    return s;
  endfunction

  task automatic run_frame(input string tag, input logic [31:0] w, input logic [31:0] h,
                           input logic [31:0] seed, input logic [31:0] ctrl, input bit good,
                           input int tmode, input logic [31:0] st_exp, input int budget);
    logic [31:0] m;
    bit seen = 0;
    m = misr_model();
    wr(32'h04, w); wr(32'h08, h); wr(32'h0C, seed); wr(32'h20, good ? m : m + 1);
    foreach (vec[i]) exp_q.push_back(vec[i]);
    done_cyc = 0;
    xfer_t.delete();
    tx_mode = tmode;
    wr(32'h00, ctrl);
    for (int i = 0; i < budget && !seen; i++) begin @(negedge clk); seen = bist_done; end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s_wait: bist_done absent after %0d cycles", tag, budget);
    end
    repeat (3) @(negedge clk);
    tx_mode = 0;
    chk({tag, "_done_pulse"}, 32'(done_cyc), 32'd1);
    rd_chk({tag, "_tx_cnt"}, 32'h14, 32'(vec.size()));
    rd_chk({tag, "_rx_cnt"}, 32'h18, echo_en ? 32'(vec.size()) : 32'd0);
    rd_chk({tag, "_status"}, 32'h10, st_exp);
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic e;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_bist_done", 32'(bist_done), 0);
    chk("rst_pready", 32'(PREADY), 1);
    chk("rst_pslverr", 32'(PSLVERR), 0);
    chk("rst_prdata", PRDATA, 0);
    chk("rst_tx_pixel", 32'(tx_pixel), 0);
    rd_chk("rst_status", 32'h10, 0);
    rd_chk("rst_sig", 32'h1C, 32'hFFFF_FFFF);
    rd_chk("rst_tx_cnt", 32'h14, 0);
    rd_chk("rst_width", 32'h04, 0);

    vec = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd4};
    run_frame("ramp", 4, 2, 0, 32'h1, 1, 0, 32'h6, 2000);
    rd_chk("ramp_sig", 32'h1C, misr_model());
    run_frame("ramp_stall", 4, 2, 0, 32'h1, 0, 1, 32'h2, 2000);

    vec = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h80, 8'h40, 8'hA0, 8'hD0};
    run_frame("lfsr", 4, 2, 1, 32'h9, 1, 0, 32'h6, 2000);
    run_frame("lfsr_seed0", 4, 2, 0, 32'h9, 1, 0, 32'h6, 2000);

    vec = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
    run_frame("checker", 10, 1, 0, 32'h5, 1, 0, 32'h6, 2000);

    vec = '{8'hA5, 8'hA5, 8'hA5, 8'hA5};
    run_frame("const", 2, 2, 32'h12A5, 32'hD, 1, 0, 32'h6, 2000);

    echo_en = 0;
    vec = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd4};
    run_frame("timeout", 4, 2, 0, 32'h1, 0, 0, 32'h12, 70000);
    chk("drain_len", 32'(done_at - last_xfer), 32'd65536);
    echo_en = 1;

    wr(32'h08, 0);
    wr(32'h00, 1);
    repeat (2) @(negedge clk);
    apb_read(32'h10, d, e);
    chk("cfg_err_status", d & 32'h9, 32'h8);
    apb_read(32'h30, d, e);
    chk("unmapped_pslverr", 32'(e), 1);
    apb_write(32'h10, 5, e);
    chk("ro_write_pslverr", 32'(e), 1);
    apb_write(32'h08, 2, e);
    chk("height_wr_pslverr", 32'(e), 0);
    rd_chk("height_readback", 32'h08, 2);

`ifdef SOBEL_BIST_HBLANK_EN
    wr(32'h24, 2);
    vec = '{8'd0, 8'd1, 8'd1, 8'd2};
    run_frame("hblank", 2, 2, 0, 32'h1, 1, 0, 32'h6, 2000);
    if (xfer_t.size() == 4) begin
      chk("hblank_line0", 32'(xfer_t[1] - xfer_t[0]), 1);
      chk("hblank_gap", 32'(xfer_t[2] - xfer_t[1]), 3);
      chk("hblank_line1", 32'(xfer_t[3] - xfer_t[2]), 1);
    end else chk("hblank_beats", 32'(xfer_t.size()), 4);
    wr(32'h24, 0);
`else
    apb_write(32'h24, 5, e);
    chk("hblank_wr_pslverr", 32'(e), 0);
    rd_chk("hblank_reads_0", 32'h24, 0);
`endif

    wr(32'h04, 4); wr(32'h08, 2);
    vec = '{8'd0, 8'd1, 8'd2};
    foreach (vec[i]) exp_q.push_back(vec[i]);
    tx_mode = 2;
    tx_ready = 0;
    wr(32'h00, 1);
    apb_write(32'h04, 7, e);
    chk("busy_wr_pslverr", 32'(e), 0);
    @(posedge clk); #1 tx_ready = 1;
    repeat (3) @(posedge clk);
    #1 tx_ready = 0;
    wr(32'h00, 2);
    @(negedge clk);
    chk("abort_tx_valid", 32'(tx_valid), 0);
    rd_chk("abort_tx_cnt", 32'h14, 3);
    apb_read(32'h10, d, e);
    chk("abort_status", d & 32'h13, 0);
    rd_chk("busy_width_dropped", 32'h04, 4);
    chk("abort_queue_empty", 32'(exp_q.size()), 0);
    tx_mode = 0;

    tx_mode = 2;
    tx_ready = 0;
    wr(32'h00, 1);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("midrst_tx_valid", 32'(tx_valid), 0);
    rd_chk("midrst_status", 32'h10, 0);
    rd_chk("midrst_width", 32'h04, 0);
    rd_chk("midrst_sig", 32'h1C, 32'hFFFF_FFFF);
    tx_mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
